// File: rtl/decoder_pkg.sv
// Shared types and helpers for the binary/one-hot stream blocks.
// onehot_of is sized for codes up to CODE_MAX_W bits; callers cast to their own width.
package decoder_pkg;

    localparam int CODE_MAX_W   = 6;
    localparam int ONEHOT_MAX_W = 1 << CODE_MAX_W;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_t;

    function automatic logic [ONEHOT_MAX_W-1:0] onehot_of(input logic [CODE_MAX_W-1:0] code);
        logic [ONEHOT_MAX_W-1:0] r;
        r       = '0;
        r[code] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/decoder_2x4_stream_if.sv
// Valid/ready code-in / one-hot-out channel plus the delivered-word counter.
// slave is the decoder side, master is the producer/consumer side.
interface decoder_2x4_stream_if #(
    parameter int IN_W  = 2,
    parameter int CNT_W = 8
);
    localparam int OUT_W = 1 << IN_W;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  w;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] y;
    logic             clr;
    logic [CNT_W-1:0] cnt;

    modport slave (
        input  in_valid, w, out_ready, clr,
        output in_ready, out_valid, y, cnt
    );

    modport master (
        output in_valid, w, out_ready, clr,
        input  in_ready, out_valid, y, cnt
    );

endinterface

// File: rtl/stream_buf2.sv
// Generic 2-entry in-order valid/ready buffer; in_ready is registered and
// never depends combinationally on out_ready.
module stream_buf2
    import decoder_pkg::*;
#(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    occ_t              state;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic              push;
    logic              pop;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = (state != OCC_EMPTY);
    assign out_data  = head;

    // NOTE: sequential state uses <= only; head/tail are payload and are left
    // unreset on purpose -- the occupancy state alone decides what is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OCC_EMPTY;
            in_ready <= 1'b0;
        end else begin
            in_ready <= 1'b1;
            case (state)
                OCC_EMPTY: begin
                    if (push) begin
                        head  <= in_data;
                        state <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && !pop) begin
                        tail     <= in_data;
                        state    <= OCC_FULL;
                        in_ready <= 1'b0;
                    end else if (push && pop) begin
                        head <= in_data;
                    end else if (pop) begin
                        state <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // push cannot happen here because in_ready is low
                    if (pop) begin
                        head  <= tail;
                        state <= OCC_ONE;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    state <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/decoder_2x4_stream.sv
// Streaming binary-to-one-hot decoder with a 2-entry buffer and a saturating
// count of delivered words. IN_W must be between 1 and CODE_MAX_W.
module decoder_2x4_stream
    import decoder_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    decoder_2x4_stream_if.slave bus
);

    localparam int OUT_W = 1 << IN_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [IN_W-1:0]  head;
    logic [CNT_W-1:0] cnt_q;
    logic             pop;

    stream_buf2 #(
        .DATA_W (IN_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (bus.w),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (head)
    );

    // Decoded from the registered head only, so no path from w reaches y.
    assign bus.y = bus.out_valid ? OUT_W'(onehot_of(CODE_MAX_W'(head))) : '0;

    assign pop     = bus.out_valid & bus.out_ready;
    assign bus.cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            cnt_q <= '0;
        end else if (pop && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
